// File: rtl/seq_player.sv
// rtl/seq_player.sv - stored-symbol sequence player driving a seven-segment digit
//
// Purpose: collects up to DEPTH 4-bit symbols, then plays them back one at a
// time. Each symbol is shown for ON_CYCLES cycles, then blanked for OFF_CYCLES
// cycles. A one-cycle done pulse marks the end of playback. Playback leaves the
// stored sequence intact, so it can be replayed.
//
// Ports:
//   clk      - sole clock, all state on rising edge
//   rst      - synchronous active-high reset
//   wr_en    - append wr_data to the sequence (IDLE only, ignored when full)
//   wr_data  - 4-bit symbol to append
//   clear    - empty the sequence (IDLE only, highest priority there)
//   start    - begin playback (IDLE only, beats wr_en)
//   count    - number of stored symbols
//   full     - count == DEPTH
//   busy     - high outside IDLE
//   done     - one-cycle pulse when playback ends (or on start with empty buffer)
//   digit    - symbol being shown, 0 when blank
//   digit_en - display enable

module seq_player #(
   parameter int DEPTH      = 16,
   parameter int ON_CYCLES  = 8,
   parameter int OFF_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [3:0]              wr_data,
   input  logic                    clear,
   input  logic                    start,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    busy,
   output logic                    done,
   output logic [3:0]              digit,
   output logic                    digit_en
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

   logic [3:0]    mem [DEPTH];

   state_t        state_q, state_nxt;
   logic [AW-1:0] index_q, index_nxt;
   logic [TW-1:0] timer_q, timer_nxt;
   logic [CW-1:0] count_nxt;
   logic          wr_fire;
   logic          done_nxt;

   logic [3:0]    digit_nxt;
   logic          digit_en_nxt;
   logic          busy_nxt;
   logic          full_nxt;

   // State register plus registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         index_q  <= '0;
         timer_q  <= '0;
         count    <= '0;
         full     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         digit    <= 4'h0;
         digit_en <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         index_q  <= index_nxt;
         timer_q  <= timer_nxt;
         count    <= count_nxt;
         full     <= full_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         digit    <= digit_nxt;
         digit_en <= digit_en_nxt;
      end
   end

   // Symbol storage is not reset; only entries below count are ever read
   always_ff @(posedge clk) begin
      if (!rst && wr_fire) begin
         mem[count[AW-1:0]] <= wr_data;
      end
   end

   // Next-state logic: clear > start > wr_en in IDLE; all inputs ignored while playing
   always_comb begin
      state_nxt = state_q;
      index_nxt = index_q;
      timer_nxt = timer_q;
      count_nxt = count;
      wr_fire   = 1'b0;
      done_nxt  = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear) begin
               count_nxt = '0;
            end else if (start) begin
               if (count != '0) begin
                  state_nxt = SHOW;
                  index_nxt = '0;
                  timer_nxt = '0;
               end else begin
                  done_nxt = 1'b1;
               end
            end else if (wr_en && !full) begin
               wr_fire   = 1'b1;
               count_nxt = count + 1'b1;
            end
         end
         SHOW: begin
            if (timer_q == ON_LAST) begin
               state_nxt = GAP;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer_q + 1'b1;
            end
         end
         GAP: begin
            if (timer_q == OFF_LAST) begin
               timer_nxt = '0;
               if ({1'b0, index_q} == count - 1'b1) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = SHOW;
                  index_nxt = index_q + 1'b1;
               end
            end else begin
               timer_nxt = timer_q + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            index_nxt = '0;
            timer_nxt = '0;
         end
      endcase
   end

   // Output logic: decoded from the upcoming state so the outputs line up with it once registered
   always_comb begin
      digit_nxt    = 4'h0;
      digit_en_nxt = 1'b0;
      busy_nxt     = (state_nxt != IDLE);
      full_nxt     = (count_nxt == DEPTH_C);
      if (state_nxt == SHOW) begin
         digit_nxt    = mem[index_nxt];
         digit_en_nxt = 1'b1;
      end
   end

endmodule

// File: tb/tb_seq_player.sv
// tb/tb_seq_player.sv - self-checking bench for seq_player

module tb_seq_player;

   localparam int DEPTH = 4;
   localparam int ON    = 3;
   localparam int OFF   = 2;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [3:0] wr_data;
   logic       clear;
   logic       start;
   logic [2:0] count;
   logic       full;
   logic       busy;
   logic       done;
   logic [3:0] digit;
   logic       digit_en;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: the stored sequence as a plain queue
   logic [3:0] q [$];

   seq_player #(
      .DEPTH      (DEPTH),
      .ON_CYCLES  (ON),
      .OFF_CYCLES (OFF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .clear    (clear),
      .start    (start),
      .count    (count),
      .full     (full),
      .busy     (busy),
      .done     (done),
      .digit    (digit),
      .digit_en (digit_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_count"}, 32'(count), 32'(q.size()));
      chk({tag, "_full"}, 32'(full), 32'(q.size() == DEPTH));
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_den"}, 32'(digit_en), 0);
      chk({tag, "_digit"}, 32'(digit), 0);
   endtask

   task automatic do_write(input logic [3:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
      if (q.size() < DEPTH) q.push_back(d);
      chk_idle("wr");
      chk("wr_done", 32'(done), 0);
   endtask

   task automatic do_clear(input bit with_wr);
      clear   = 1'b1;
      wr_en   = with_wr;
      wr_data = 4'h9;
      tick();
      clear   = 1'b0;
      wr_en   = 1'b0;
      q.delete();
      chk_idle("clr");
   endtask

   // Expected playback derived from the queue: each symbol ON cycles lit, OFF cycles blank
   task automatic play(input bit junk, input bit wr_too);
      int n;
      int busy_cycles;
      n = q.size();
      start   = 1'b1;
      wr_en   = wr_too;
      wr_data = 4'hE;
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      if (n == 0) begin
         chk("empty_done", 32'(done), 1);
         chk_idle("empty");
         tick();
         chk("empty_done_end", 32'(done), 0);
         chk_idle("empty_after");
         return;
      end
      busy_cycles = 0;
      for (int s = 0; s < n; s++) begin
         for (int c = 0; c < ON + OFF; c++) begin
            if (busy) busy_cycles++;
            chk("play_den", 32'(digit_en), 32'(c < ON));
            chk("play_digit", 32'(digit), (c < ON) ? 32'(q[s]) : 0);
            chk("play_done", 32'(done), 0);
            chk("play_count", 32'(count), 32'(n));
            if (junk) begin
               wr_en   = 1'($urandom);
               clear   = 1'($urandom);
               start   = 1'($urandom);
               wr_data = 4'($urandom);
            end
            tick();
         end
      end
      wr_en = 1'b0;
      clear = 1'b0;
      start = 1'b0;
      chk("play_busy_cycles", 32'(busy_cycles), 32'(n * (ON + OFF)));
      chk("play_done_pulse", 32'(done), 1);
      chk_idle("play_end");
      tick();
      chk("play_done_end", 32'(done), 0);
   endtask

   initial begin
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_data = 4'h0;
      clear   = 1'b0;
      start   = 1'b0;

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      chk_idle("reset");
      chk("reset_done", 32'(done), 0);

      // Three-symbol playback 5, A, 3
      do_write(4'h5);
      do_write(4'hA);
      do_write(4'h3);
      play(1'b0, 1'b0);

      // Start with empty buffer
      do_clear(1'b0);
      play(1'b0, 1'b0);

      // Fill to DEPTH, extra write of F must be dropped and never shown
      for (int i = 0; i < DEPTH; i++) do_write(4'($urandom_range(0, 14)));
      do_write(4'hF);
      chk("full_flag", 32'(full), 1);
      chk("full_count", 32'(count), DEPTH);
      play(1'b0, 1'b0);

      // clear and wr_en together, then start and wr_en together
      do_clear(1'b1);
      do_write(4'h7);
      do_write(4'h2);
      play(1'b0, 1'b1);
      chk("start_wr_count", 32'(count), 2);

      // Noise on start/wr_en/clear during playback, then identical replay
      play(1'b1, 1'b0);
      play(1'b0, 1'b0);

      // Reset during the second SHOW of a three-symbol playback
      do_clear(1'b0);
      do_write(4'h1);
      do_write(4'h8);
      do_write(4'hC);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < ON + OFF + 1; i++) tick();
      chk("rst_mid_den", 32'(digit_en), 1);
      chk("rst_mid_digit", 32'(digit), 32'(q[1]));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q.delete();
      chk_idle("rst_mid");
      chk("rst_mid_done", 32'(done), 0);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("rst_after_done", 32'(done), 0);
         chk("rst_after_busy", 32'(busy), 0);
      end

      // Randomized mix of operations against the queue model
      for (int k = 0; k < 40; k++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 5) do_write(4'($urandom));
         else if (r == 6) do_clear(1'($urandom));
         else play(1'($urandom), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
